pcpi_issuer: RTL
================

# pcpi_issuer

Initiator side of the PCPI coprocessor interface. It accepts an M-extension operation (funct3, two 32-bit operands, destination index) on a valid/ready command port. It then drives a PCPI responder such as the divider or multiplier until `pcpi_ready`, and returns the result, write flag, latency and a timeout flag on a valid/ready response port. It sits between the core's execute stage, or a benchmark harness, and any PCPI coprocessor. It lets coprocessors be exercised in hardware without the full core.

## Interface
- `TIMEOUT_CYCLES`, 16: number of consecutive cycles with `pcpi_valid` high and both `pcpi_wait` and `pcpi_ready` low that ends the transaction as a timeout (≥1).
- `CNT_W`, 16: width of the latency counter `rsp_cycles`.

Ports:
- `clk` in 1: the single clock; everything is sampled on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: a command is offered.
- `cmd_ready` out 1: the block can accept a command.
- `cmd_funct3` in 3: M-extension funct3.
- `cmd_rd` in 5: destination register index, placed in the instruction.
- `cmd_rs1` in 32: operand 1.
- `cmd_rs2` in 32: operand 2.
- `pcpi_valid` out 1: instruction is presented to the coprocessor.
- `pcpi_insn` out 32: R-type instruction word.
- `pcpi_rs1` out 32: operand 1 to the coprocessor.
- `pcpi_rs2` out 32: operand 2 to the coprocessor.
- `pcpi_wr` in 1: coprocessor writes rd.
- `pcpi_rd` in 32: coprocessor result.
- `pcpi_wait` in 1: coprocessor has claimed the instruction and is busy.
- `pcpi_ready` in 1: coprocessor result is valid.
- `rsp_valid` out 1: a response is held.
- `rsp_ready` in 1: the consumer accepts the response.
- `rsp_data` out 32: captured `pcpi_rd`, or 0 on timeout.
- `rsp_wr` out 1: captured `pcpi_wr`, or 0 on timeout.
- `rsp_timeout` out 1: the transaction ended by timeout.
- `rsp_cycles` out `CNT_W`: number of edges `pcpi_valid` was high, saturating.

## Operation
- The FSM has three states: IDLE, ISSUE and RESP.
- `cmd_ready` = (state == IDLE), decoded combinationally from the state.
- **IDLE.** On `cmd_valid && cmd_ready`:
  - latch the operands into `pcpi_rs1`/`pcpi_rs2`;
  - build `pcpi_insn` = {7'b0000001, 5'd2, 5'd1, cmd_funct3, cmd_rd, 7'b0110011};
  - set `pcpi_valid` = 1, clear the latency and timeout counters, go to ISSUE.
- **ISSUE.**
  - `pcpi_valid`, `pcpi_insn`, `pcpi_rs1` and `pcpi_rs2` are held stable.
  - `rsp_cycles` increments every edge and saturates at all-ones.
  - The timeout counter increments on edges where both `pcpi_wait` and `pcpi_ready` are low, and clears on edges where `pcpi_wait` is high.
  - `pcpi_ready` high: capture `rsp_data` = `pcpi_rd` and `rsp_wr` = `pcpi_wr`; set `rsp_timeout` = 0 and `rsp_valid` = 1; drop `pcpi_valid`; go to RESP.
  - Otherwise, when the timeout counter reaches `TIMEOUT_CYCLES`: set `rsp_data` = 0, `rsp_wr` = 0, `rsp_timeout` = 1 and `rsp_valid` = 1; drop `pcpi_valid`; go to RESP.
  - If `pcpi_ready` is high on the same edge the timeout would fire, `pcpi_ready` wins.
- **RESP.** All `rsp_*` outputs are held stable. On `rsp_ready`: clear `rsp_valid` and go to IDLE.
- Any funct3 value (0–7) is issued unchanged. The block performs no arithmetic and no result checking.
- `pcpi_ready`, `pcpi_wait` and `pcpi_wr` are ignored in IDLE and RESP.

## Timing
- **Reset values** (after a `reset` edge): state IDLE, so `cmd_ready` = 1; every other output is 0, including `pcpi_insn`, `pcpi_rs1`, `pcpi_rs2`, `rsp_data` and `rsp_cycles`.
- **Reset mid-operation** (in ISSUE or RESP) aborts the transaction:
  - no response is produced;
  - `pcpi_valid` is low after that edge.
- **Command to coprocessor:** a command accepted at edge N gives `pcpi_valid` = 1 from after N.
- **Coprocessor to response:** `pcpi_ready` sampled high at edge M gives `rsp_valid` = 1 and `pcpi_valid` = 0 from after M. `rsp_cycles` then counts edges N+1..M inclusive, so a same-cycle responder yields `rsp_cycles` = 1.
- **Timeout:** `TIMEOUT_CYCLES` idle edges after N give `rsp_valid` at edge N + `TIMEOUT_CYCLES`.
- **Throughput:** response accepted at edge R gives `cmd_ready` = 1 after R. One transaction is outstanding at a time, and there is at least a 1-cycle gap between transactions.
- **Stability:** outputs change only on `clk` edges, except `cmd_ready`.

## Test plan
- **DIV 20/3.** Command funct3=100, rs1=20, rs2=3. Model divider asserts wait, then ready after 34 cycles with rd=6 and wr=1. Required: `rsp_data`=6, `rsp_wr`=1, `rsp_timeout`=0, `rsp_cycles`=34.
- **Instruction encoding.** funct3=110, rd=5. Required: `pcpi_insn`=0x0220E2B3, held stable through ISSUE. `pcpi_rs1`/`pcpi_rs2` equal the command operands (0xFFFFFFFF, 2).
- **Timeout.** `TIMEOUT_CYCLES`=8 with no responder. Required: `rsp_valid` exactly 8 edges after issue, `rsp_timeout`=1, `rsp_data`=0, `rsp_wr`=0, `pcpi_valid` low afterwards.
- **Response backpressure.** `rsp_ready` held low 5 cycles after a DIVU 0xFFFFFFFF/2 response. Required: `rsp_data`=0x7FFFFFFF stable, `cmd_ready`=0 throughout, IDLE one edge after `rsp_ready`.
- **Reset mid-ISSUE.** Assert `reset` 3 cycles after issue. Required: `pcpi_valid`=0, no `rsp_valid`, `cmd_ready`=1; the next command completes normally.
- **Ready/timeout collision and stale ready.** `pcpi_ready` arrives on the timeout edge: required `rsp_timeout`=0 with data captured. `pcpi_ready` pulsed in IDLE: required no response.

Source files
------------

// File: rtl/pcpi_issuer.sv
// PCPI initiator: issues one M-extension op to a coprocessor and returns result, write flag, latency and timeout.
// One transaction outstanding; cmd_ready only in IDLE, response held until rsp_ready.
module pcpi_issuer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_funct3,
  input  logic [4:0]       cmd_rd,
  input  logic [31:0]      cmd_rs1,
  input  logic [31:0]      cmd_rs2,
  output logic             pcpi_valid,
  output logic [31:0]      pcpi_insn,
  output logic [31:0]      pcpi_rs1,
  output logic [31:0]      pcpi_rs2,
  input  logic             pcpi_wr,
  input  logic [31:0]      pcpi_rd,
  input  logic             pcpi_wait,
  input  logic             pcpi_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_wr,
  output logic             rsp_timeout,
  output logic [CNT_W-1:0] rsp_cycles
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

  state_t            state_q, state_d;
  logic              pvalid_q, pvalid_d;
  logic [31:0]       insn_q, insn_d;
  logic [31:0]       rs1_q, rs1_d;
  logic [31:0]       rs2_q, rs2_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rwr_q, rwr_d;
  logic              rto_q, rto_d;
  logic [CNT_W-1:0]  cycles_q, cycles_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

  logic [TO_W-1:0]   to_inc;
  logic              pcpi_idle;
  logic              timeout_hit;

  // The counter fires on the edge that would take it to the limit, so the
  // response appears exactly TIMEOUT_CYCLES idle edges after issue.
  assign to_inc      = to_cnt_q + TO_W'(1);
  assign pcpi_idle   = !pcpi_wait && !pcpi_ready;
  assign timeout_hit = pcpi_idle && (to_inc == TO_LIMIT);

  always_comb begin
    state_d  = state_q;
    pvalid_d = pvalid_q;
    insn_d   = insn_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rwr_d    = rwr_q;
    rto_d    = rto_q;
    cycles_d = cycles_q;
    to_cnt_d = to_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          rs1_d    = cmd_rs1;
          rs2_d    = cmd_rs2;
          insn_d   = {7'b0000001, 5'd2, 5'd1, cmd_funct3, cmd_rd, 7'b0110011};
          pvalid_d = 1'b1;
          cycles_d = '0;
          to_cnt_d = '0;
          state_d  = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (cycles_q != {CNT_W{1'b1}}) begin
          cycles_d = cycles_q + CNT_W'(1);
        end
        if (pcpi_wait) begin
          to_cnt_d = '0;
        end else if (!pcpi_ready) begin
          to_cnt_d = to_inc;
        end

        // A ready arriving on the timeout edge takes priority.
        if (pcpi_ready) begin
          rdata_d  = pcpi_rd;
          rwr_d    = pcpi_wr;
          rto_d    = 1'b0;
          rvalid_d = 1'b1;
          pvalid_d = 1'b0;
          state_d  = S_RESP;
        end else if (timeout_hit) begin
          rdata_d  = '0;
          rwr_d    = 1'b0;
          rto_d    = 1'b1;
          rvalid_d = 1'b1;
          pvalid_d = 1'b0;
          state_d  = S_RESP;
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          rvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d  = S_IDLE;
        pvalid_d = 1'b0;
        rvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pvalid_q <= 1'b0;
      insn_q   <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rwr_q    <= 1'b0;
      rto_q    <= 1'b0;
      cycles_q <= '0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      pvalid_q <= pvalid_d;
      insn_q   <= insn_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rwr_q    <= rwr_d;
      rto_q    <= rto_d;
      cycles_q <= cycles_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  assign cmd_ready   = (state_q == S_IDLE);
  assign pcpi_valid  = pvalid_q;
  assign pcpi_insn   = insn_q;
  assign pcpi_rs1    = rs1_q;
  assign pcpi_rs2    = rs2_q;
  assign rsp_valid   = rvalid_q;
  assign rsp_data    = rdata_q;
  assign rsp_wr      = rwr_q;
  assign rsp_timeout = rto_q;
  assign rsp_cycles  = cycles_q;

endmodule
